// File: rtl/sha2_multimode_pkg.sv
// rtl/sha2_multimode_pkg.sv - SHA-2 constants, types and round helper functions
// Purpose: round constants, both IVs, mode/state enums and the shared
//          schedule and compression-round functions.
// Ports:   none (package).
package sha2_multimode_pkg;

   localparam int NumRound = 64;

   typedef enum logic {Sha256 = 1'b0, Sha224 = 1'b1} mode_e;
   typedef enum logic [1:0] {StIdle, StLoad, StCompress, StUpdate} state_e;

   // Element 0 sits in the MSBs, so H0/W0 line up with digest[255:224].
   typedef logic [0:7][31:0]  hash_t;
   typedef logic [0:15][31:0] sched_t;

   localparam logic [31:0] K [NumRound] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   localparam hash_t Iv256 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                              32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
   localparam hash_t Iv224 = {32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                              32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] shiftr(input logic [31:0] x, input int n);
      return x >> n;
   endfunction

   // Next schedule word from the 16-word sliding window (W0 is the oldest).
   function automatic logic [31:0] calc_w(input sched_t w);
      logic [31:0] s0, s1;
      s0 = rotr(w[1], 7) ^ rotr(w[1], 18) ^ shiftr(w[1], 3);
      s1 = rotr(w[14], 17) ^ rotr(w[14], 19) ^ shiftr(w[14], 10);
      return w[0] + s0 + w[9] + s1;
   endfunction

   function automatic hash_t compress_round(input hash_t h, input logic [31:0] k,
                                            input logic [31:0] w);
      logic [31:0] t1, t2;
      t1 = h[7] + (rotr(h[4], 6) ^ rotr(h[4], 11) ^ rotr(h[4], 25))
         + ((h[4] & h[5]) ^ (~h[4] & h[6])) + k + w;
      t2 = (rotr(h[0], 2) ^ rotr(h[0], 13) ^ rotr(h[0], 22))
         + ((h[0] & h[1]) ^ (h[0] & h[2]) ^ (h[1] & h[2]));
      return {t1 + t2, h[0], h[1], h[2], h[3] + t1, h[4], h[5], h[6]};
   endfunction

endpackage

// File: rtl/sha2_round_unroll.sv
// rtl/sha2_round_unroll.sv - combinational chain of RoundsPerCycle SHA-2 rounds
// Purpose: applies RoundsPerCycle consecutive rounds and schedule shifts.
// Ports:   w_i/w_o   schedule window in/out
//          h_i/h_o   working hash in/out
//          round_i   index of the first round applied this cycle
module sha2_round_unroll
   import sha2_multimode_pkg::*;
#(
   parameter int RoundsPerCycle = 1
) (
   input  sched_t     w_i,
   input  hash_t      h_i,
   input  logic [5:0] round_i,
   output sched_t     w_o,
   output hash_t      h_o
);

   sched_t w_c [RoundsPerCycle+1];
   hash_t  h_c [RoundsPerCycle+1];

   assign w_c[0] = w_i;
   assign h_c[0] = h_i;

   for (genvar i = 0; i < RoundsPerCycle; i++) begin : g_round
      logic [5:0] rnd;
      assign rnd       = round_i + 6'(i);
      assign h_c[i+1]  = compress_round(h_c[i], K[rnd], w_c[i][0]);
      // The last 16 rounds only drain the window; nothing new is needed.
      assign w_c[i+1]  = {w_c[i][1:15], (rnd >= 6'd48) ? 32'h0 : calc_w(w_c[i])};
   end

   assign w_o = w_c[RoundsPerCycle];
   assign h_o = h_c[RoundsPerCycle];

endmodule

// File: rtl/sha2_multimode.sv
// rtl/sha2_multimode.sv - SHA-256/SHA-224 compression engine with round unrolling
// Purpose: accepts pre-padded 16-word blocks, compresses them and presents the
//          chained digest with a done pulse; reports framing errors.
// Ports:   clk_i, rst_i             clock, synchronous active-high reset
//          sha_en                   low aborts and clears all state
//          mode_i, hash_start       mode select (0 SHA-256, 1 SHA-224), message start
//          wipe_secret, wipe_v      XOR wipe of W, working hash and digest
//          msg_valid/data/last/ready  word input handshake
//          hash_done, digest, err_o   result pulse, digest, framing error pulse
module sha2_multimode
   import sha2_multimode_pkg::*;
#(
   parameter int RoundsPerCycle = 1
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         sha_en,
   input  logic         mode_i,
   input  logic         hash_start,
   input  logic         wipe_secret,
   input  logic [31:0]  wipe_v,
   input  logic         msg_valid,
   input  logic [31:0]  msg_data,
   input  logic         msg_last,
   output logic         msg_ready,
   output logic         hash_done,
   output logic [255:0] digest,
   output logic         err_o
);

   if (!(RoundsPerCycle == 1 || RoundsPerCycle == 2 || RoundsPerCycle == 4)) begin : g_bad_rpc
      $error("sha2_multimode: RoundsPerCycle must be 1, 2 or 4");
   end

   state_e     state_q, state_d;
   mode_e      mode_q, mode_d;
   sched_t     w_q, w_d, w_rnd;
   hash_t      wh_q, wh_d, wh_rnd;
   hash_t      digest_q, digest_d;
   logic [5:0] round_q, round_d;
   logic [3:0] cnt_q, cnt_d;
   logic       last_q, last_d, done_q, done_d, err_q, err_d;

   sha2_round_unroll #(.RoundsPerCycle(RoundsPerCycle)) u_unroll (
      .w_i     (w_q),
      .h_i     (wh_q),
      .round_i (round_q),
      .w_o     (w_rnd),
      .h_o     (wh_rnd)
   );

   // Words are only taken when no higher-priority control acts this cycle,
   // so a handshake never coincides with a cycle that ignores the word.
   assign msg_ready = (state_q == StLoad) && !rst_i && !wipe_secret && sha_en && !hash_start;
   assign hash_done = done_q;
   assign err_o     = err_q;
   assign digest    = (mode_q == Sha224 && state_q == StIdle) ? {digest_q[0:6], 32'h0}
                                                               : digest_q;

   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      w_d      = w_q;
      wh_d     = wh_q;
      digest_d = digest_q;
      round_d  = round_q;
      cnt_d    = cnt_q;
      last_d   = last_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      if (wipe_secret) begin
         w_d      = w_q ^ {16{wipe_v}};
         wh_d     = wh_q ^ {8{wipe_v}};
         digest_d = digest_q ^ {8{wipe_v}};
      end else if (!sha_en) begin
         state_d  = StIdle;
         mode_d   = Sha256;
         w_d      = '0;
         wh_d     = '0;
         digest_d = '0;
         round_d  = '0;
         cnt_d    = '0;
         last_d   = 1'b0;
      end else if (hash_start) begin
         state_d  = StLoad;
         mode_d   = mode_e'(mode_i);
         digest_d = mode_i ? Iv224 : Iv256;
         round_d  = '0;
         cnt_d    = '0;
         last_d   = 1'b0;
      end else begin
         case (state_q)
            StLoad: begin
               if (msg_valid && msg_ready) begin
                  if (msg_last && cnt_q != 4'd15) begin
                     err_d   = 1'b1;
                     state_d = StIdle;
                     cnt_d   = '0;
                  end else begin
                     w_d    = {w_q[1:15], msg_data};
                     cnt_d  = cnt_q + 4'd1;
                     last_d = msg_last;
                     if (cnt_q == 4'd15) begin
                        state_d = StCompress;
                        wh_d    = digest_q;
                        round_d = '0;
                     end
                  end
               end
            end
            StCompress: begin
               w_d     = w_rnd;
               wh_d    = wh_rnd;
               round_d = round_q + 6'(RoundsPerCycle);
               if (round_q == 6'(NumRound - RoundsPerCycle)) begin
                  round_d = '0;
                  state_d = StUpdate;
               end
            end
            StUpdate: begin
               for (int i = 0; i < 8; i++) digest_d[i] = digest_q[i] + wh_q[i];
               cnt_d = '0;
               if (last_q) begin
                  done_d  = 1'b1;
                  state_d = StIdle;
               end else begin
                  state_d = StLoad;
               end
            end
            default: state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= StIdle;
         mode_q   <= Sha256;
         w_q      <= '0;
         wh_q     <= '0;
         digest_q <= '0;
         round_q  <= '0;
         cnt_q    <= '0;
         last_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         w_q      <= w_d;
         wh_q     <= wh_d;
         digest_q <= digest_d;
         round_q  <= round_d;
         cnt_q    <= cnt_d;
         last_q   <= last_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

endmodule

// File: tb/tb_sha2_multimode.sv
// tb/tb_sha2_multimode.sv - self-checking bench for sha2_multimode (R = 1, 2, 4)
module tb_sha2_multimode;

   typedef logic [0:7][31:0] h_t;

   localparam logic [31:0] KT [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
   localparam h_t IV256 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                           32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
   localparam h_t IV224 = {32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                           32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
   localparam logic [255:0] ABC256 = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] ABC224 = 256'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da700000000;
   localparam logic [255:0] TWO256 = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
   localparam logic [255:0] EMP256 = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

   logic         clk = 1'b0;
   logic         rst, sha_en, mode, hstart, wipe, mvalid, mlast;
   logic [31:0]  wipe_v, mdata;
   logic         rdy [3];
   logic         done [3];
   logic         err [3];
   logic [255:0] dig [3];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      sha2_multimode #(.RoundsPerCycle(1 << g)) u_dut (
         .clk_i       (clk),
         .rst_i       (rst),
         .sha_en      (sha_en),
         .mode_i      (mode),
         .hash_start  (hstart),
         .wipe_secret (wipe),
         .wipe_v      (wipe_v),
         .msg_valid   (mvalid),
         .msg_data    (mdata),
         .msg_last    (mlast),
         .msg_ready   (rdy[g]),
         .hash_done   (done[g]),
         .digest      (dig[g]),
         .err_o       (err[g])
      );
   end

   int           n_tests = 0;
   int           n_fail  = 0;
   logic [31:0]  mw [48];
   int           lat [3];
   logic [255:0] dres [3];

   task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: textbook SHA-256 compression with a fully expanded 64-word schedule.
   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      logic [63:0] y;
      y = {x, x} >> n;
      return y[31:0];
   endfunction

   function automatic h_t model_block(input h_t hin, input logic [31:0] blk [16]);
      logic [31:0] w [64];
      logic [31:0] v [8];
      logic [31:0] t1, t2;
      h_t          hout;
      for (int t = 0; t < 16; t++) w[t] = blk[t];
      for (int t = 16; t < 64; t++)
         w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
              + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
      for (int i = 0; i < 8; i++) v[i] = hin[i];
      for (int t = 0; t < 64; t++) begin
         t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
            + ((v[4] & v[5]) | (~v[4] & v[6])) + KT[t] + w[t];
         t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
            + ((v[0] & v[1]) | (v[2] & (v[0] | v[1])));
         for (int i = 7; i > 0; i--) v[i] = v[i-1];
         v[4] = v[4] + t1;
         v[0] = t1 + t2;
      end
      for (int i = 0; i < 8; i++) hout[i] = hin[i] + v[i];
      return hout;
   endfunction

   function automatic logic [255:0] model_msg(input bit m, input int nblk);
      h_t          h;
      logic [31:0] blk [16];
      h = m ? IV224 : IV256;
      for (int b = 0; b < nblk; b++) begin
         for (int i = 0; i < 16; i++) blk[i] = mw[b*16+i];
         h = model_block(h, blk);
      end
      if (m) h[7] = 32'h0;
      return h;
   endfunction

   task automatic start_msg(input bit m);
      mode   = m;
      hstart = 1'b1;
      @(negedge clk);
      hstart = 1'b0;
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send_word(input logic [31:0] d, input bit last, input bit stall, output int waited);
      waited = 0;
      if (stall) repeat ($urandom_range(1, 3)) @(negedge clk);
      mvalid = 1'b1;
      mdata  = d;
      mlast  = last;
      #1;
      while (!rdy[0] && waited < 200) begin
         @(negedge clk);
         #1;
         waited++;
      end
      if (!rdy[0]) check_eq("ready_timeout", rdy[0], 1);
      @(posedge clk);
      @(negedge clk);
      mvalid = 1'b0;
      mlast  = 1'b0;
   endtask

   task automatic send_block(input int base, input bit last_blk, input bit stall, output int first_wait);
      int wt;
      first_wait = 0;
      for (int i = 0; i < 16; i++) begin
         send_word(mw[base+i], last_blk && (i == 15), stall, wt);
         if (i == 0) first_wait = wt;
      end
   endtask

   task automatic wait_done(input int ninst);
      for (int g = 0; g < 3; g++) lat[g] = 0;
      for (int c = 1; c <= 80; c++) begin
         @(negedge clk);
         for (int g = 0; g < ninst; g++)
            if (done[g] && lat[g] == 0) begin
               lat[g]  = c + 1;
               dres[g] = dig[g];
            end
      end
      for (int g = 0; g < ninst; g++)
         if (lat[g] == 0) check_eq($sformatf("done_timeout_r%0d", 1 << g), 0, 1);
   endtask

   task automatic load_abc();
      for (int i = 0; i < 16; i++) mw[i] = 32'h0;
      mw[0]  = 32'h61626380;
      mw[15] = 32'h00000018;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int  wt, nb;
      bit  m, flag;
      rst = 1'b1; sha_en = 1'b1; mode = 1'b0; hstart = 1'b0; wipe = 1'b0;
      wipe_v = 32'h0; mvalid = 1'b0; mdata = 32'h0; mlast = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_digest", dig[0], 0);
      check_eq("rst_ready", rdy[0], 0);
      check_eq("rst_done", done[0], 0);
      check_eq("rst_err", err[0], 0);
      rst = 1'b0;
      @(negedge clk);

      // "abc" on all three unroll factors, digest and latency
      load_abc();
      start_msg(1'b0);
      send_block(0, 1'b1, 1'b0, wt);
      wait_done(3);
      for (int g = 0; g < 3; g++) begin
         check_eq($sformatf("abc256_digest_r%0d", 1 << g), dres[g], ABC256);
         check_eq($sformatf("abc256_latency_r%0d", 1 << g), lat[g], 64 / (1 << g) + 2);
      end
      check_eq("abc256_model", dres[0], model_msg(1'b0, 1));

      // wipe in Idle inverts the digest
      wipe = 1'b1; wipe_v = 32'hffffffff;
      @(negedge clk);
      wipe = 1'b0;
      check_eq("wipe_digest", dig[0], ~ABC256);

      // SHA-224 "abc"
      start_msg(1'b1);
      send_block(0, 1'b1, 1'b0, wt);
      wait_done(1);
      check_eq("abc224_digest", dres[0], ABC224);

      // two-block SHA-256, msg_ready low through Compress/Update of block 1
      for (int i = 0; i < 14; i++)
         mw[i] = {8'(8'h61 + i), 8'(8'h62 + i), 8'(8'h63 + i), 8'(8'h64 + i)};
      mw[14] = 32'h80000000;
      mw[15] = 32'h0;
      for (int i = 16; i < 32; i++) mw[i] = 32'h0;
      mw[31] = 32'h000001c0;
      start_msg(1'b0);
      send_block(0, 1'b0, 1'b0, wt);
      send_block(16, 1'b1, 1'b0, wt);
      check_eq("twoblk_ready_low_cycles", wt, 65);
      wait_done(1);
      check_eq("twoblk_digest", dres[0], TWO256);

      // empty message, without and with stalls
      for (int i = 0; i < 16; i++) mw[i] = 32'h0;
      mw[0] = 32'h80000000;
      for (int s = 0; s < 2; s++) begin
         start_msg(1'b0);
         send_block(0, 1'b1, s[0], wt);
         wait_done(1);
         check_eq($sformatf("empty_digest_stall%0d", s), dres[0], EMP256);
      end

      // framing error: msg_last on word 5
      start_msg(1'b0);
      for (int i = 0; i < 5; i++) send_word(32'h1000 + i, i == 4, 1'b0, wt);
      check_eq("err_pulse", err[0], 1);
      @(negedge clk);
      check_eq("err_pulse_width", err[0], 0);
      check_eq("err_idle_ready", rdy[0], 0);
      flag = 1'b0;
      repeat (70) begin
         @(negedge clk);
         if (done[0]) flag = 1'b1;
      end
      check_eq("err_no_done", flag, 0);
      check_eq("err_digest_iv", dig[0], IV256);

      // abort mid-Compress, then a clean restart
      load_abc();
      start_msg(1'b0);
      send_block(0, 1'b1, 1'b0, wt);
      repeat (10) @(negedge clk);
      sha_en = 1'b0;
      @(negedge clk);
      check_eq("abort_digest", dig[0], 0);
      check_eq("abort_ready", rdy[0], 0);
      check_eq("abort_done", done[0], 0);
      check_eq("abort_err", err[0], 0);
      sha_en = 1'b1;
      @(negedge clk);
      start_msg(1'b0);
      send_block(0, 1'b1, 1'b0, wt);
      wait_done(1);
      check_eq("abort_restart_digest", dres[0], ABC256);

      // randomized messages against the reference model
      for (int k = 0; k < 8; k++) begin
         m  = 1'($urandom_range(0, 1));
         nb = $urandom_range(1, 3);
         for (int i = 0; i < nb * 16; i++) mw[i] = $urandom;
         if (k % 2 == 1) begin
            start_msg(1'b0);
            for (int i = 0; i < 7; i++) send_word($urandom, 1'b0, 1'b0, wt);
         end
         start_msg(m);
         for (int b = 0; b < nb; b++) send_block(b * 16, b == nb - 1, k[0], wt);
         wait_done(1);
         check_eq($sformatf("rand%0d_m%0d_b%0d", k, m, nb), dres[0], model_msg(m, nb));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sha2_multimode.md
Name: sha2_multimode

Overview:
- Next-generation SHA-2 compression engine for the HMAC/SHA datapath. Supports SHA-256 and SHA-224 selected per message, with a parametrised number of compression rounds per clock.
- Consumes pre-padded 512-bit blocks as a stream of 16 big-endian 32-bit words from the padding stage.
- Produces the final digest and a done pulse.
- Adds mode selection, multi-round unrolling, a framing-error report and a clean abort path.

Parameters:
- RoundsPerCycle, 1, compression rounds per clock; legal values 1, 2, 4. Elaboration error otherwise.
- NumRound, 64, rounds per block; fixed constant, not overridable.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active high.
- sha_en  in  1  engine enable; low aborts and clears all state.
- mode_i  in  1  0 = SHA-256, 1 = SHA-224; sampled on hash_start.
- hash_start  in  1  pulse; loads IV for sampled mode, begins a message.
- wipe_secret  in  1  XOR wipe_v into W, working hash and digest this cycle.
- wipe_v  in  32  wipe pattern.
- msg_valid  in  1  message word valid.
- msg_data  in  32  message word, big-endian, already padded.
- msg_last  in  1  qualifies msg_valid; marks the final word of the final block.
- msg_ready  out  1  word accepted when msg_valid & msg_ready.
- hash_done  out  1  one-cycle pulse; digest is final.
- digest  out  256  H0 in [255:224] through H7 in [31:0]; in SHA-224 mode [31:0] reads zero.
- err_o  out  1  one-cycle pulse on framing error.

Behaviour:
- Reset (rst_i high at a clock edge):
  - State goes to Idle.
  - digest, W, working hash, round, word count all clear.
  - msg_ready, hash_done, err_o are 0.
- Priority, highest first: rst_i, wipe_secret, !sha_en (clear to reset values except the wipe), hash_start, normal operation.
- hash_start:
  - Loads digest with the IV for mode_i. SHA-256 IV is 6a09e667..5be0cd19. SHA-224 IV is c1059ed8 367cd507 3070dd17 f70e5939 ffc00b31 68581511 64f98fa7 befa4fa4.
  - Goes to Load with word count 0.
  - If asserted outside Idle, the current message is abandoned and restarted.
- FSM Idle:
  - msg_ready = 0.
  - Goes to Load on hash_start.
- FSM Load:
  - msg_ready = 1.
  - Each accepted word shifts into W[15], increments the word count, and latches last_q = msg_last.
  - On the 16th word, go to Compress and initialise the working hash from digest the same cycle.
  - msg_last on words 1 to 15: err_o pulses, the word is dropped, and the FSM returns to Idle with digest unchanged.
- FSM Compress:
  - msg_ready = 0.
  - Performs RoundsPerCycle rounds per cycle, chaining combinationally, for 64/RoundsPerCycle cycles.
  - Each round consumes W[0] and K[round]. The schedule extends via w_new = W0 + s0(W1) + W9 + s1(W14), with rounds >= 48 shifting in zero.
  - round advances by RoundsPerCycle and wraps 60→0 (R=4), 62→0 (R=2) or 63→0 (R=1).
  - On the last cycle, go to Update.
- FSM Update (1 cycle):
  - digest[i] += working hash[i], for i = 0..7, all modulo 2^32.
  - If last_q is set: hash_done pulses next cycle and the FSM goes to Idle.
  - Otherwise the FSM goes to Load.
- Per-block latency after the 16th word handshake: 64/RoundsPerCycle + 1 cycles to Update completion, then hash_done one cycle later.
- SHA-224 output: digest[31:0] is forced to zero when hash_done is presented. Internal H7 is retained until Idle.
- msg_valid with msg_ready low has no effect. Upstream holds the word.
- All arithmetic is 32-bit and wraps. No saturation.

Decomposition:
- Package sha2_multimode_pkg holds:
  - the K table (64×32) and both IV constants;
  - the mode enum (Sha256, Sha224) and the FSM state enum;
  - functions rotr, shiftr, calc_w and compress_round.
- One sub-module, sha2_round_unroll: combinational chain of RoundsPerCycle rounds and schedule updates. The top level holds the FSM, counters and registers.

Test Plan:
- SHA-256 "abc": block words 0x61626380, 14×0, 0x00000018, with msg_last on word 16 → digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad. Run for R=1, 2, 4; done 66/34/18 cycles after the last word.
- SHA-224 "abc", same block, mode_i=1 → digest 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7 00000000.
- Two-block SHA-256 of "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" → 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1. msg_ready must be low during Compress/Update.
- Empty message (0x80000000, 15×0) → e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855. Then insert random msg_valid stalls and check the same result.
- msg_last on word 5 → err_o pulse, Idle, no hash_done, digest still equals the IV.
- Abort and wipe:
  - sha_en low mid-Compress → all outputs zero next cycle; a new hash_start then gives the correct "abc" digest.
  - wipe_secret with wipe_v=0xFFFFFFFF in Idle after "abc" → digest words inverted.
